apb_master_arbiter: RTL and testbench

- Shares the single APB register-file slave (cntrl at 0x0, data registers at 0x4/0x8/0xC/0x10) between NREQ local requesters.
- Arbitrates requests round-robin and sequences the APB SETUP/ACCESS phases.
- The slave has no pready and registers prdata one cycle after ACCESS, so this block captures read data in a dedicated capture cycle before returning a response.
- Rejects out-of-map or unaligned addresses locally, without touching the bus.

---
 rtl/apb_master_arbiter.sv | 161 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter that shares one APB register-file
// slave between NREQ local requesters. It runs one APB transfer at a time,
// spends an extra cycle capturing read data (the slave registers prdata one
// cycle after ACCESS), and rejects out-of-map or unaligned addresses locally.
module apb_master_arbiter #(
    parameter int          NREQ     = 2,
    parameter logic [31:0] MAX_ADDR = 32'h10
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [31:0]          paddr,
    output logic [31:0]          pwdata,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    input  logic [31:0]          prdata
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        RCAP   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   r_id;
    logic             r_write;
    logic             r_err;
    logic [31:0]      r_paddr;
    logic [31:0]      r_pwdata;
    logic [31:0]      r_rdata;

    logic [IDW-1:0]   w_winner;
    logic             w_found;
    logic             w_accept;
    logic             w_legal;
    logic             w_write;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;

    // Round-robin pick: lowest requester above the last grant, else lowest overall.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        w_found  = 1'b0;
        w_winner = r_last;
        // Descending scans make the last hit the lowest index; the second scan
        // (requesters above the last grant) overrides the wrap-around scan.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) <= r_last)) begin
                w_found  = 1'b1;
                w_winner = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) > r_last)) begin
                w_found  = 1'b1;
                w_winner = IDW'(i);
            end
        end
    end

    // Select the winner's payload and classify its address.
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_winner) begin
                w_addr  = req_addr[i*32 +: 32];
                w_wdata = req_wdata[i*32 +: 32];
                w_write = req_write[i];
            end
        end
        w_legal  = (w_addr <= MAX_ADDR) && (w_addr[1:0] == 2'b00);
        w_accept = (r_state == IDLE) && presetn && w_found;
    end

    // Next-state sequencing of the APB phases.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_legal ? SETUP : RESP;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = r_write ? RESP : RCAP;
            RCAP:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, grant pointer, latched request and response data registers.
    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (!presetn) begin
            r_state  <= IDLE;
            r_last   <= IDW'(NREQ - 1);
            r_id     <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last  <= w_winner;
                r_id    <= w_winner;
                r_write <= w_write;
                r_err   <= !w_legal;
                // Rejected requests never reach the bus, so paddr/pwdata keep
                // the last legal transfer's values.
                if (w_legal) begin
                    r_paddr  <= w_addr;
                    r_pwdata <= w_wdata;
                end
            end
            // rsp_rdata changes only on entry to RESP: captured data for a
            // read, zero for a write or an address error.
            if (r_state == RCAP) begin
                r_rdata <= prdata;
            end else if (w_next == RESP) begin
                r_rdata <= '0;
            end
        end
    end

    // Decode bus, handshake and response outputs from state and pointers.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_accept && (IDW'(i) == w_winner);
            rsp_valid[i] = (r_state == RESP) && (IDW'(i) == r_id);
        end
        psel      = (r_state == SETUP) || (r_state == ACCESS);
        penable   = (r_state == ACCESS);
        pwrite    = psel && r_write;
        busy      = (r_state != IDLE);
        rsp_err   = (r_state == RESP) && r_err;
        rsp_rdata = r_rdata;
        paddr     = r_paddr;
        pwdata    = r_pwdata;
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed test-plan scenarios followed by randomized
// traffic with occasional resets. A transaction-level model (round-robin pick
// by modular arithmetic, fixed per-kind phase timeline, word-array register
// file) predicts every output on every cycle; literal expectations pin it.
module tb_apb_master_arbiter;

    localparam int          NREQ     = 2;
    localparam logic [31:0] MAX_ADDR = 32'h10;
    localparam int          BUDGET   = 300;
    localparam int          K_WR     = 0;
    localparam int          K_RD     = 1;
    localparam int          K_ERR    = 2;

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; int gap; } txn_t;
    typedef struct { int id; logic err; logic [31:0] rdata; int cyc; } rsp_t;
    typedef struct { int id; int cyc; } gnt_t;

    logic                pclk    = 1'b0;
    logic                presetn = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_write;
    logic [NREQ*32-1:0]  req_addr;
    logic [NREQ*32-1:0]  req_wdata;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic                busy;
    logic [31:0]         paddr;
    logic [31:0]         pwdata;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [31:0]         prdata;

    apb_master_arbiter #(.NREQ(NREQ), .MAX_ADDR(MAX_ADDR)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .paddr(paddr), .pwdata(pwdata), .psel(psel),
        .penable(penable), .pwrite(pwrite), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Slave register file: cntrl at 0x0, data at 0x4..0x10; prdata registered
    // at the end of ACCESS; cleared by presetn.
    logic [31:0] s_regs [5];
    always @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < 5; i++) s_regs[i] <= '0;
            prdata <= '0;
        end else if (psel && penable) begin
            if (pwrite) s_regs[paddr[4:2]] <= pwdata;
            else        prdata <= s_regs[paddr[4:2]];
        end
    end

    // Requester drivers: hold each request until accepted, then pop the next.
    txn_t            rq [NREQ][$];
    logic [NREQ-1:0] holding;
    int              gap_cnt  [NREQ];
    int              wait_cnt [NREQ];

    task automatic push(input int i, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int gap);
        txn_t t;
        t.w = w; t.a = a; t.d = d; t.gap = gap;
        rq[i].push_back(t);
    endtask

    initial begin
        logic [NREQ-1:0] acc;
        txn_t            t;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; holding = '0;
        for (int i = 0; i < NREQ; i++) begin gap_cnt[i] = 0; wait_cnt[i] = 0; end
        forever begin
            @(negedge pclk);
            acc = req_ready & req_valid;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (holding[i] && acc[i]) begin
                    holding[i] = 1'b0; req_valid[i] = 1'b0;
                end else if (holding[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > BUDGET) begin
                        fail_bound($sformatf("accept_timeout_req%0d", i));
                        holding[i] = 1'b0; req_valid[i] = 1'b0;
                    end
                end
                if (!holding[i] && rq[i].size() > 0) begin
                    if (gap_cnt[i] < rq[i][0].gap) begin
                        gap_cnt[i]++;
                    end else begin
                        t = rq[i].pop_front();
                        gap_cnt[i] = 0; wait_cnt[i] = 0; holding[i] = 1'b1;
                        req_valid[i] = 1'b1; req_write[i] = t.w;
                        req_addr[i*32 +: 32] = t.a; req_wdata[i*32 +: 32] = t.d;
                    end
                end
            end
        end
    end

    // Behavioural model state.
    bit          m_init = 0;
    bit          m_active = 0;
    int          m_last, m_id, m_kind, m_age, m_len;
    logic [31:0] m_rd, e_paddr, e_pwdata, e_rdata;
    logic [31:0] m_mem [5];

    // Monitor logs used by the literal expectations.
    rsp_t        rsp_log[$];
    gnt_t        gnt_log[$];
    int          psel_cnt = 0;
    int          setup_cyc = 0, acc_cyc = 0;
    logic [31:0] acc_addr = '0, acc_data = '0;

    logic [NREQ-1:0] p_hold = '0;
    logic [31:0]     p_addr [NREQ];

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Compare process: log, check every output against the model, advance it.
    always @(negedge pclk) begin : cmp
        logic [NREQ-1:0] e_ready, e_rv;
        logic            e_psel, e_pen, e_pw, e_err;
        logic [31:0]     a, d;
        int              w;
        rsp_t            r;
        gnt_t            g;

        if (rsp_valid != '0) begin
            r.id = -1;
            for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) r.id = i;
            r.err = rsp_err; r.rdata = rsp_rdata; r.cyc = cyc;
            rsp_log.push_back(r);
        end
        if (req_ready != '0) begin
            g.id = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g.id = i;
            g.cyc = cyc;
            gnt_log.push_back(g);
        end
        if (psel) psel_cnt++;
        if (psel && !penable) setup_cyc = cyc;
        if (psel && penable) begin acc_cyc = cyc; acc_addr = paddr; acc_data = pwdata; end

        for (int i = 0; i < NREQ; i++) begin
            if (p_hold[i]) check($sformatf("contract_hold_req%0d", i),
                                 64'({req_valid[i], req_addr[i*32 +: 32]}), 64'({1'b1, p_addr[i]}));
        end

        if (m_init) begin
            e_ready = '0; e_rv = '0; e_psel = 1'b0; e_pen = 1'b0; e_pw = 1'b0; e_err = 1'b0;
            if (!m_active) begin
                w = rr_pick(req_valid, m_last);
                if (presetn && w >= 0) e_ready = NREQ'(1) << w;
            end else begin
                if (m_kind != K_ERR && m_age <= 2) begin
                    e_psel = 1'b1; e_pen = (m_age == 2); e_pw = (m_kind == K_WR);
                end
                if (m_age == m_len) begin
                    e_rv    = NREQ'(1) << m_id;
                    e_err   = (m_kind == K_ERR);
                    e_rdata = (m_kind == K_RD) ? m_rd : 32'h0;
                end
            end
            check("req_ready", 64'(req_ready), 64'(e_ready));
            check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            check("rsp_err",   64'(rsp_err),   64'(e_err));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
            check("busy",      64'(busy),      64'(m_active));
            check("psel",      64'(psel),      64'(e_psel));
            check("penable",   64'(penable),   64'(e_pen));
            check("pwrite",    64'(pwrite),    64'(e_pw));
            check("paddr",     64'(paddr),     64'(e_paddr));
            check("pwdata",    64'(pwdata),    64'(e_pwdata));
        end

        if (!presetn) begin
            m_init = 1; m_active = 0; m_last = NREQ - 1;
            e_paddr = '0; e_pwdata = '0; e_rdata = '0;
            for (int i = 0; i < 5; i++) m_mem[i] = '0;
        end else if (m_init) begin
            if (!m_active) begin
                w = rr_pick(req_valid, m_last);
                if (w >= 0) begin
                    a = req_addr[w*32 +: 32]; d = req_wdata[w*32 +: 32];
                    m_last = w; m_id = w; m_active = 1; m_age = 1;
                    if (a > MAX_ADDR || (a % 4) != 0) begin
                        m_kind = K_ERR; m_len = 1;
                    end else begin
                        e_paddr = a; e_pwdata = d;
                        if (req_write[w]) begin
                            m_kind = K_WR; m_len = 3; m_mem[a[4:2]] = d;
                        end else begin
                            m_kind = K_RD; m_len = 4; m_rd = m_mem[a[4:2]];
                        end
                    end
                end
            end else if (m_age == m_len) begin
                m_active = 0;
            end else begin
                m_age++;
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            p_hold[i] = req_valid[i] && !req_ready[i];
            p_addr[i] = req_addr[i*32 +: 32];
        end
    end

    task automatic wait_idle();
        int  n = 0;
        bit  idle;
        do begin
            @(negedge pclk);
            n++;
            idle = (holding == '0) && (req_valid == '0) && !busy;
            for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) idle = 0;
        end while (!idle && n < 2000);
        if (!idle) fail_bound("wait_idle");
        tick();
    endtask

    task automatic check_rsp(input string tag, input int id, input logic err,
                             input logic [31:0] rd, input int lat);
        rsp_t r;
        gnt_t g;
        if (rsp_log.size() == 0 || gnt_log.size() == 0) begin
            fail_bound({tag, "_no_response"});
        end else begin
            r = rsp_log[rsp_log.size() - 1];
            g = gnt_log[gnt_log.size() - 1];
            check({tag, "_id"},      64'(r.id),          64'(id));
            check({tag, "_err"},     64'(r.err),         64'(err));
            check({tag, "_rdata"},   64'(r.rdata),       64'(rd));
            check({tag, "_latency"}, 64'(r.cyc - g.cyc), 64'(lat));
        end
    endtask

    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g0, p0, n0, n;
        txn_t t;

        // 1: reset with every requester asserting.
        presetn = 1'b0;
        push(0, 1'b0, 32'h0, 32'h0, 0);
        push(1, 1'b0, 32'h0, 32'h0, 0);
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            check("t1_rst_psel",      64'(psel),      64'(0));
            check("t1_rst_penable",   64'(penable),   64'(0));
            check("t1_rst_req_ready", 64'(req_ready), 64'(0));
            check("t1_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        end
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(negedge pclk);
        check("t1_first_ready", 64'(req_ready), 64'(2'b01));
        wait_idle();

        // 2: requester 0 writes 0xDEADBEEF to 0x4.
        push(0, 1'b1, 32'h4, 32'hDEADBEEF, 0);
        wait_idle();
        check_rsp("t2", 0, 1'b0, 32'h0, 3);
        check("t2_setup_offset",  64'(setup_cyc - gnt_log[gnt_log.size()-1].cyc), 64'(1));
        check("t2_access_offset", 64'(acc_cyc - gnt_log[gnt_log.size()-1].cyc),   64'(2));
        check("t2_access_paddr",  64'(acc_addr), 64'(32'h4));
        check("t2_access_pwdata", 64'(acc_data), 64'(32'hDEADBEEF));

        // 3: reads return previously written data.
        push(1, 1'b0, 32'h4, 32'h0, 0);
        wait_idle();
        check_rsp("t3a", 1, 1'b0, 32'hDEADBEEF, 4);
        push(0, 1'b1, 32'h0, 32'h5, 0);
        wait_idle();
        push(1, 1'b0, 32'h0, 32'h0, 0);
        wait_idle();
        check_rsp("t3b", 1, 1'b0, 32'h5, 4);

        // 4: both requesters hammer 0x8; grants alternate every 4 cycles.
        g0 = gnt_log.size();
        for (int k = 0; k < 4; k++) begin
            push(0, 1'b1, 32'h8, 32'h1111, 0);
            push(1, 1'b1, 32'h8, 32'h2222, 0);
        end
        wait_idle();
        check("t4_grant_count", 64'(gnt_log.size() - g0), 64'(8));
        for (int k = 0; k < 8 && g0 + k < gnt_log.size(); k++) begin
            check($sformatf("t4_grant%0d_id", k), 64'(gnt_log[g0+k].id), 64'(k % 2));
            if (k > 0) check($sformatf("t4_grant%0d_spacing", k),
                             64'(gnt_log[g0+k].cyc - gnt_log[g0+k-1].cyc), 64'(4));
        end
        push(0, 1'b0, 32'h8, 32'h0, 0);
        wait_idle();
        check_rsp("t4_rd", 0, 1'b0, 32'h2222, 4);

        // 5: out-of-map and unaligned addresses never reach the bus.
        p0 = psel_cnt;
        push(0, 1'b1, 32'h14, 32'h99, 0);
        wait_idle();
        check_rsp("t5a", 0, 1'b1, 32'h0, 1);
        push(0, 1'b0, 32'h6, 32'h0, 0);
        wait_idle();
        check_rsp("t5b", 0, 1'b1, 32'h0, 1);
        check("t5_psel_cycles", 64'(psel_cnt - p0), 64'(0));

        // 6: reset during ACCESS drops the transfer.
        n0 = rsp_log.size();
        push(0, 1'b1, 32'hC, 32'h12345678, 0);
        n = 0;
        do begin @(negedge pclk); n++; end while (!(psel && !penable) && n < BUDGET);
        if (!(psel && !penable)) fail_bound("t6_wait_setup");
        @(posedge pclk); #1;
        presetn = 1'b0;
        @(negedge pclk);
        check("t6_in_access", 64'({psel, penable}), 64'(2'b11));
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(negedge pclk);
        check("t6_psel_after", 64'(psel), 64'(0));
        check("t6_busy_after", 64'(busy), 64'(0));
        wait_idle();
        check("t6_no_rsp", 64'(rsp_log.size() - n0), 64'(0));
        push(0, 1'b1, 32'h10, 32'hA5A5, 0);
        wait_idle();
        check_rsp("t6_wr", 0, 1'b0, 32'h0, 3);
        push(0, 1'b0, 32'h10, 32'h0, 0);
        wait_idle();
        check_rsp("t6_rd10", 0, 1'b0, 32'hA5A5, 4);
        push(0, 1'b0, 32'hC, 32'h0, 0);
        wait_idle();
        check_rsp("t6_rdC", 0, 1'b0, 32'h0, 4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 60; k++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                t.w = 1'($urandom_range(0, 1));
                if (sel < 8)       t.a = 32'($urandom_range(0, 4)) << 2;
                else if (sel == 8) t.a = 32'h14 + (32'($urandom_range(0, 15)) << 2);
                else               t.a = (32'($urandom_range(0, 4)) << 2) + 32'($urandom_range(1, 3));
                t.d   = $urandom;
                t.gap = int'($urandom_range(0, 3));
                rq[i].push_back(t);
            end
        end
        n = 0;
        while ((rq[0].size() != 0 || rq[1].size() != 0) && n < 5000) begin
            if ($urandom_range(0, 119) == 0) begin
                presetn = 1'b0;
                tick();
                presetn = 1'b1;
            end
            tick();
            n++;
        end
        wait_idle();
        check("rand_all_issued", 64'(rq[0].size() + rq[1].size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
